// File: rtl/vram_arbiter_if.sv
// Handshake and RAM bus bundle for vram_arbiter: prefetch read port, pixel write port, pixel RAM port.
interface vram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 12
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_data_valid;
    logic              rd_done;
    logic              rd_overrun;
    logic              wr_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output rd_data, rd_data_valid, rd_done, rd_overrun, wr_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  rd_data, rd_data_valid, rd_done, rd_overrun, wr_ready,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/vram_arbiter.sv
// Pixel RAM arbiter: high-priority line-prefetch bursts vs. low-priority stream writes.
// Optional VRAM_STATS_EN adds a saturating write-stall counter (wr_stall_cnt, clr_stats).
module vram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 12,
    parameter int BURST_LEN = 8,
    parameter int WR_SLOTS  = 1
) (
    input  logic            clk,
    input  logic            reset,
    vram_arbiter_if.slave   bus,
    output logic            busy
`ifdef VRAM_STATS_EN
    ,
    input  logic            clr_stats,
    output logic [15:0]     wr_stall_cnt
`endif
);
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int SLOT_W = (WR_SLOTS > 0) ? $clog2(WR_SLOTS + 1) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD_BURST, RD_DRAIN} state_t;

    state_t              state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic                rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0]   cap_addr_q;
    logic                overrun_q;
    logic                mem_en_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                valid_q, done_q;

    logic                req_busy;
    logic                wr_ready_c;
    logic                issue_en, issue_we;
    logic [ADDR_W-1:0]   issue_addr;
    logic [DATA_W-1:0]   issue_wdata;

    assign req_busy = rd_pend_q || (state_q != IDLE);

    // Memory controls are registered from next-state values, so the access issued in the
    // IDLE->RD_BURST decision cycle appears on the RAM pins in the first RD_BURST cycle.
    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        slot_d      = slot_q;
        rd_pend_d   = rd_pend_q;
        wr_ready_c  = 1'b0;
        issue_en    = 1'b0;
        issue_we    = 1'b0;
        issue_addr  = mem_addr_q;
        issue_wdata = mem_wdata_q;

        if (bus.rd_req && !req_busy)
            rd_pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                wr_ready_c = (!rd_pend_q || (slot_q != '0)) && !bus.rd_req;
                if (bus.wr_valid && wr_ready_c) begin
                    issue_en    = 1'b1;
                    issue_we    = 1'b1;
                    issue_addr  = bus.wr_addr;
                    issue_wdata = bus.wr_data;
                    if (slot_q != '0)
                        slot_d = slot_q - SLOT_W'(1);
                end
                if (rd_pend_q && ((slot_q == '0) || !bus.wr_valid)) begin
                    state_d    = RD_BURST;
                    rd_pend_d  = 1'b0;
                    beat_d     = '0;
                    issue_en   = 1'b1;
                    issue_addr = cap_addr_q;
                end
            end
            RD_BURST: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = RD_DRAIN;
                end else begin
                    beat_d     = beat_q + BEAT_W'(1);
                    issue_en   = 1'b1;
                    issue_addr = cap_addr_q + ADDR_W'(beat_d);
                end
            end
            RD_DRAIN: begin
                state_d = IDLE;
                slot_d  = SLOT_W'(WR_SLOTS);
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            slot_q      <= SLOT_W'(WR_SLOTS);
            rd_pend_q   <= 1'b0;
            cap_addr_q  <= '0;
            overrun_q   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            slot_q      <= slot_d;
            rd_pend_q   <= rd_pend_d;
            if (bus.rd_req && !req_busy)
                cap_addr_q <= bus.rd_addr;
            if (bus.rd_req && req_busy)
                overrun_q <= 1'b1;
            mem_en_q    <= issue_en;
            mem_we_q    <= issue_we;
            mem_addr_q  <= issue_addr;
            mem_wdata_q <= issue_wdata;
            valid_q     <= mem_en_q && !mem_we_q;
            done_q      <= (state_q == RD_BURST) && (state_d == RD_DRAIN);
        end
    end

    assign bus.rd_data       = bus.mem_rdata;
    assign bus.rd_data_valid = valid_q;
    assign bus.rd_done       = done_q;
    assign bus.rd_overrun    = overrun_q;
    assign bus.wr_ready      = wr_ready_c;
    assign bus.mem_en        = mem_en_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign busy              = (state_q != IDLE);

`ifdef VRAM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            wr_stall_cnt <= '0;
        else if (clr_stats)
            wr_stall_cnt <= '0;
        else if (bus.wr_valid && !wr_ready_c && (wr_stall_cnt != '1))
            wr_stall_cnt <= wr_stall_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// Directed self-checking bench for vram_arbiter (BURST_LEN=8, WR_SLOTS=1) with a behavioural pixel RAM.
module tb_vram_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    vram_arbiter_if #(.ADDR_W(16), .DATA_W(12)) bus ();

`ifdef VRAM_STATS_EN
    logic        clr_stats = 1'b0;
    logic [15:0] wr_stall_cnt;
`endif

    vram_arbiter #(.ADDR_W(16), .DATA_W(12), .BURST_LEN(8), .WR_SLOTS(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .busy  (busy)
`ifdef VRAM_STATS_EN
        ,
        .clr_stats    (clr_stats),
        .wr_stall_cnt (wr_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] ram_f(input logic [15:0] a);
        return a[11:0] ^ 12'h5A5;
    endfunction

    // Read-only RAM model with one-cycle latency; reads return a known address hash.
    always @(posedge clk)
        if (bus.mem_en && !bus.mem_we)
            bus.mem_rdata <= ram_f(bus.mem_addr);

    task automatic cyc;
        @(negedge clk);
    endtask

    task automatic test_reset;
        bus.rd_req = 0; bus.rd_addr = '0; bus.wr_valid = 0; bus.wr_addr = '0; bus.wr_data = '0;
        bus.mem_rdata = '0;
        reset = 0;
        cyc; cyc;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got %b exp 0", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0000", bus.mem_addr); end
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.rd_data_valid); end
        checks++; if (bus.rd_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", bus.rd_done); end
        checks++; if (bus.rd_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", bus.rd_overrun); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        reset = 1;
        cyc;
    endtask

    task automatic test_write;
        cyc;
        bus.wr_valid = 1; bus.wr_addr = 16'h0123; bus.wr_data = 12'hABC; #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL write_ready got %b exp 1", bus.wr_ready); end
        cyc;
        checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL write_en got %b exp 1", bus.mem_en); end
        checks++; if (bus.mem_we !== 1'b1) begin errors++; $display("FAIL write_we got %b exp 1", bus.mem_we); end
        checks++; if (bus.mem_addr !== 16'h0123) begin errors++; $display("FAIL write_addr got %h exp 0123", bus.mem_addr); end
        checks++; if (bus.mem_wdata !== 12'hABC) begin errors++; $display("FAIL write_wdata got %h exp abc", bus.mem_wdata); end
        bus.wr_valid = 0;
        cyc;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL write_en_after got %b exp 0", bus.mem_en); end
    endtask

    // Slot counter is exhausted by test_write, so the burst must win the same-cycle conflict.
    task automatic test_rd_wr_conflict;
        logic [15:0] ea;
        cyc;
        bus.rd_req = 1; bus.rd_addr = 16'h0200;
        bus.wr_valid = 1; bus.wr_addr = 16'h0456; bus.wr_data = 12'h789; #1;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready_t0 got %b exp 0", bus.wr_ready); end
        cyc;
        bus.rd_req = 0; #1;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready_t1 got %b exp 0", bus.wr_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL conflict_busy_t1 got %b exp 0", busy); end
        for (int k = 2; k <= 10; k++) begin
            cyc;
            ea = 16'h0200 + 16'(k - 2);
            checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL conflict_ready_t%0d got %b exp 0", k, bus.wr_ready); end
            checks++; if (bus.mem_en !== (k <= 9)) begin errors++; $display("FAIL conflict_en_t%0d got %b exp %b", k, bus.mem_en, (k <= 9)); end
            if (k <= 9) begin
                checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== ea) begin errors++; $display("FAIL conflict_rd_t%0d got we=%b addr=%h exp we=0 addr=%h", k, bus.mem_we, bus.mem_addr, ea); end
            end
        end
        checks++; if (bus.rd_done !== 1'b1) begin errors++; $display("FAIL conflict_done got %b exp 1", bus.rd_done); end
        cyc;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL conflict_ready_after got %b exp 1", bus.wr_ready); end
        cyc;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0456 || bus.mem_wdata !== 12'h789) begin
            errors++; $display("FAIL conflict_write got we=%b addr=%h data=%h exp we=1 addr=0456 data=789", bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        bus.wr_valid = 0;
        cyc;
    endtask

    task automatic test_burst;
        logic [15:0] starts [2];
        logic [15:0] a, ea, da;
        logic        exp_en, exp_valid, exp_done, exp_busy;
        starts[0] = 16'h0010; starts[1] = 16'hFFFC;
        for (int s = 0; s < 2; s++) begin
            a = starts[s];
            cyc;
            bus.rd_req = 1; bus.rd_addr = a;
            cyc;
            bus.rd_req = 0;
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL burst%0d_busy_t1 got %b exp 0", s, busy); end
            for (int k = 2; k <= 11; k++) begin
                cyc;
                ea = a + 16'(k - 2);
                da = a + 16'(k - 3);
                exp_en = (k <= 9); exp_valid = (k >= 3 && k <= 10); exp_done = (k == 10); exp_busy = (k <= 10);
                checks++; if (bus.mem_en !== exp_en) begin errors++; $display("FAIL burst%0d_en_t%0d got %b exp %b", s, k, bus.mem_en, exp_en); end
                if (exp_en) begin
                    checks++; if (bus.mem_we !== 1'b0 || bus.mem_addr !== ea) begin errors++; $display("FAIL burst%0d_addr_t%0d got we=%b addr=%h exp we=0 addr=%h", s, k, bus.mem_we, bus.mem_addr, ea); end
                end
                checks++; if (bus.rd_data_valid !== exp_valid) begin errors++; $display("FAIL burst%0d_valid_t%0d got %b exp %b", s, k, bus.rd_data_valid, exp_valid); end
                if (exp_valid) begin
                    checks++; if (bus.rd_data !== ram_f(da)) begin errors++; $display("FAIL burst%0d_data_t%0d got %h exp %h", s, k, bus.rd_data, ram_f(da)); end
                end
                checks++; if (bus.rd_done !== exp_done) begin errors++; $display("FAIL burst%0d_done_t%0d got %b exp %b", s, k, bus.rd_done, exp_done); end
                checks++; if (busy !== exp_busy) begin errors++; $display("FAIL burst%0d_busy_t%0d got %b exp %b", s, k, busy, exp_busy); end
            end
        end
    endtask

    task automatic test_overrun;
        int n_en, n_done;
        logic [15:0] ea;
        n_en = 0; n_done = 0;
        checks++; if (bus.rd_overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got %b exp 0", bus.rd_overrun); end
        cyc;
        bus.rd_req = 1; bus.rd_addr = 16'h0300;
        for (int k = 1; k <= 16; k++) begin
            cyc;
            if (bus.mem_en) begin
                ea = 16'h0300 + 16'(n_en);
                checks++; if (bus.mem_addr !== ea) begin errors++; $display("FAIL overrun_addr_beat%0d got %h exp %h", n_en, bus.mem_addr, ea); end
                n_en++;
            end
            if (bus.rd_done) n_done++;
            bus.rd_req = (k == 4); bus.rd_addr = 16'h0800;
        end
        bus.rd_req = 0;
        checks++; if (n_en != 8) begin errors++; $display("FAIL overrun_beats got %0d exp 8", n_en); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL overrun_done_count got %0d exp 1", n_done); end
        checks++; if (bus.rd_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b exp 1", bus.rd_overrun); end
        repeat (3) cyc;
        checks++; if (bus.rd_overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b exp 1", bus.rd_overrun); end
    endtask

    // With a slot available, a write owed at the burst decision is serviced before the burst.
    task automatic test_back_to_back;
        cyc;
        bus.rd_req = 1; bus.rd_addr = 16'h0500;
        bus.wr_valid = 1; bus.wr_addr = 16'h0ACE; bus.wr_data = 12'h321; #1;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t0 got %b exp 0", bus.wr_ready); end
        cyc;
        bus.rd_req = 0; #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t1 got %b exp 1", bus.wr_ready); end
        cyc;
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0ACE || bus.mem_wdata !== 12'h321) begin
            errors++; $display("FAIL b2b_write got en=%b we=%b addr=%h data=%h exp en=1 we=1 addr=0ace data=321", bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_t2 got %b exp 0", busy); end
        bus.wr_valid = 0; #1;
        checks++; if (bus.wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t2 got %b exp 0", bus.wr_ready); end
        cyc;
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_we !== 1'b0 || bus.mem_addr !== 16'h0500) begin
            errors++; $display("FAIL b2b_read got en=%b we=%b addr=%h exp en=1 we=0 addr=0500", bus.mem_en, bus.mem_we, bus.mem_addr); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_t3 got %b exp 1", busy); end
        repeat (10) cyc;
    endtask

    task automatic test_reset_mid_burst;
        int n_done, n_en;
        n_done = 0; n_en = 0;
        cyc;
        bus.rd_req = 1; bus.rd_addr = 16'h0400;
        cyc;
        bus.rd_req = 0;
        repeat (5) cyc;
        checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 16'h0404) begin errors++; $display("FAIL rstmid_beat4 got en=%b addr=%h exp en=1 addr=0404", bus.mem_en, bus.mem_addr); end
        reset = 0; #1;
        checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rstmid_en got %b exp 0", bus.mem_en); end
        checks++; if (bus.rd_data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", bus.rd_data_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
        cyc;
        reset = 1;
        for (int k = 0; k < 12; k++) begin
            cyc;
            if (bus.rd_done) n_done++;
            if (bus.mem_en) n_en++;
        end
        checks++; if (n_done != 0) begin errors++; $display("FAIL rstmid_done_count got %0d exp 0", n_done); end
        checks++; if (n_en != 0) begin errors++; $display("FAIL rstmid_en_count got %0d exp 0", n_en); end
        checks++; if (bus.rd_overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b exp 0", bus.rd_overrun); end
        bus.wr_valid = 1; bus.wr_addr = 16'h0777; bus.wr_data = 12'h0F0; #1;
        checks++; if (bus.wr_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", bus.wr_ready); end
        cyc;
        checks++; if (bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0777) begin errors++; $display("FAIL rstmid_write got we=%b addr=%h exp we=1 addr=0777", bus.mem_we, bus.mem_addr); end
        bus.wr_valid = 0;
        cyc;
    endtask

    initial begin
        test_reset;
        test_write;
        test_rd_wr_conflict;
        test_burst;
        test_overrun;
        test_back_to_back;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
